// File: rtl/axi_lite_arbiter.sv
// AXI-Lite master arbiter between instruction fetch and data access.
// One outstanding transaction; data wins over fetch when both pending.
module axi_lite_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  input  logic        flush,
  output logic        arbiter_stall_req,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } state_t;

  state_t state;
  logic   own_data;
  logic   kill;
  logic   inst_done_q;
  logic   data_done_q;
  logic   inst_done;
  logic   data_done;
  logic   inst_pend;
  logic   data_pend;
  logic   aw_ok;
  logic   w_ok;
  logic   drop;

  assign inst_done = inst_done_q | inst_ack;
  assign data_done = data_done_q | data_ack;
  assign inst_pend = inst_req & ~inst_done;
  assign data_pend = data_req & ~data_done;
  assign arbiter_stall_req = inst_pend | data_pend;

  assign aw_ok = ~awvalid | awready;
  assign w_ok  = ~wvalid | wready;
  assign drop  = kill | flush;

  // done flags live until the pipeline advances or is flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else if (!arbiter_stall_req || flush) begin
      inst_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      inst_done_q <= inst_done;
      data_done_q <= data_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      own_data   <= 1'b0;
      kill       <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      // a flushed transaction still finishes on the bus
      if (state != IDLE && flush)
        kill <= 1'b1;
      unique case (state)
        IDLE: begin
          if (data_pend) begin
            own_data <= 1'b1;
            kill     <= flush;
            if (data_we) begin
              awaddr  <= data_addr;
              wdata   <= data_wdata;
              wstrb   <= data_sel;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_ADDR;
            end else begin
              araddr  <= data_addr;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end else if (inst_pend) begin
            own_data <= 1'b0;
            kill     <= flush;
            araddr   <= inst_addr;
            arvalid  <= 1'b1;
            state    <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= IDLE;
            if (!drop) begin
              if (own_data) begin
                data_rdata <= rdata;
                data_ack   <= 1'b1;
              end else begin
                inst_rdata <= rdata;
                inst_ack   <= 1'b1;
              end
            end
          end
        end
        WR_ADDR: begin
          if (awvalid && awready)
            awvalid <= 1'b0;
          if (wvalid && wready)
            wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= IDLE;
            if (!drop)
              data_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter.
// Slave handshakes are driven by hand, cycle by cycle.
module tb_axi_lite_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ack;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        flush;
  logic        stall;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  axi_lite_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_rdata        (inst_rdata),
    .inst_ack          (inst_ack),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_sel          (data_sel),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_rdata        (data_rdata),
    .data_ack          (data_ack),
    .flush             (flush),
    .arbiter_stall_req (stall),
    .araddr            (araddr),
    .arvalid           (arvalid),
    .arready           (arready),
    .rdata             (rdata),
    .rvalid            (rvalid),
    .rready            (rready),
    .awaddr            (awaddr),
    .awvalid           (awvalid),
    .awready           (awready),
    .wdata             (wdata),
    .wstrb             (wstrb),
    .wvalid            (wvalid),
    .wready            (wready),
    .bvalid            (bvalid),
    .bready            (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 1'b0;
    inst_addr = '0;
    data_req = 1'b0;
    data_we = 1'b0;
    data_sel = '0;
    data_addr = '0;
    data_wdata = '0;
    flush = 1'b0;
    arready = 1'b0;
    rdata = '0;
    rvalid = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    repeat (2) step;

    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_iack", inst_ack, 0);
    chk("rst_dack", data_ack, 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;

    // single fetch, slave ready at once
    inst_req = 1'b1;
    inst_addr = 32'hBFC0_0000;
    arready = 1'b1;
    #1;
    chk("t1_stall_c0", stall, 1);
    chk("t1_arvalid_c0", arvalid, 0);
    step;
    chk("t1_arvalid_c1", arvalid, 1);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    step;
    chk("t1_arvalid_c2", arvalid, 0);
    chk("t1_rready_c2", rready, 1);
    rvalid = 1'b1;
    rdata = 32'h3C08_BFAF;
    step;
    rvalid = 1'b0;
    rdata = '0;
    #1;
    chk("t1_iack_c3", inst_ack, 1);
    chk("t1_irdata", inst_rdata, 32'h3C08_BFAF);
    chk("t1_rready_c3", rready, 0);
    chk("t1_stall_c3", stall, 0);
    inst_req = 1'b0;
    step;
    chk("t1_iack_c4", inst_ack, 0);
    chk("t1_irdata_hold", inst_rdata, 32'h3C08_BFAF);
    chk("t1_arvalid_c4", arvalid, 0);

    // simultaneous fetch and load: data first
    inst_req = 1'b1;
    inst_addr = 32'hBFC0_0004;
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h8000_0010;
    step;
    chk("t2_arvalid_c1", arvalid, 1);
    chk("t2_araddr_d", araddr, 32'h8000_0010);
    step;
    chk("t2_rready_c2", rready, 1);
    rvalid = 1'b1;
    rdata = 32'hDDDD_1111;
    step;
    rvalid = 1'b0;
    #1;
    chk("t2_dack_c3", data_ack, 1);
    chk("t2_drdata", data_rdata, 32'hDDDD_1111);
    chk("t2_iack_c3", inst_ack, 0);
    chk("t2_stall_c3", stall, 1);
    step;
    chk("t2_arvalid_c4", arvalid, 1);
    chk("t2_araddr_i", araddr, 32'hBFC0_0004);
    chk("t2_dack_c4", data_ack, 0);
    chk("t2_stall_c4", stall, 1);
    step;
    chk("t2_rready_c5", rready, 1);
    rvalid = 1'b1;
    rdata = 32'h27BD_FFE8;
    step;
    rvalid = 1'b0;
    #1;
    chk("t2_iack_c6", inst_ack, 1);
    chk("t2_irdata", inst_rdata, 32'h27BD_FFE8);
    chk("t2_drdata_hold", data_rdata, 32'hDDDD_1111);
    chk("t2_stall_c6", stall, 0);
    inst_req = 1'b0;
    data_req = 1'b0;
    step;

    // store with split aw/w handshakes
    arready = 1'b0;
    data_req = 1'b1;
    data_we = 1'b1;
    data_addr = 32'h8000_1000;
    data_wdata = 32'h1234_5678;
    data_sel = 4'h3;
    awready = 1'b1;
    step;
    chk("t3_awvalid_c1", awvalid, 1);
    chk("t3_wvalid_c1", wvalid, 1);
    chk("t3_awaddr", awaddr, 32'h8000_1000);
    chk("t3_wdata", wdata, 32'h1234_5678);
    chk("t3_wstrb", wstrb, 4'h3);
    step;
    chk("t3_awvalid_c2", awvalid, 0);
    chk("t3_wvalid_c2", wvalid, 1);
    awready = 1'b0;
    step;
    chk("t3_wvalid_c3", wvalid, 1);
    chk("t3_bready_c3", bready, 0);
    wready = 1'b1;
    step;
    wready = 1'b0;
    chk("t3_wvalid_c4", wvalid, 0);
    chk("t3_bready_c4", bready, 1);
    chk("t3_dack_c4", data_ack, 0);
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    #1;
    chk("t3_dack_c5", data_ack, 1);
    chk("t3_bready_c5", bready, 0);
    chk("t3_drdata_hold", data_rdata, 32'hDDDD_1111);
    chk("t3_stall_c5", stall, 0);
    data_req = 1'b0;
    data_we = 1'b0;
    step;
    chk("t3_dack_c6", data_ack, 0);

    // flush while waiting for a slow read response
    arready = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'hBFC0_0008;
    step;
    chk("t4_arvalid_c1", arvalid, 1);
    step;
    chk("t4_rready_c2", rready, 1);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("t4_rready_c3", rready, 1);
    for (int i = 4; i < 8; i++) begin
      step;
      chk($sformatf("t4_rready_c%0d", i), rready, 1);
      chk($sformatf("t4_iack_c%0d", i), inst_ack, 0);
    end
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    step;
    rvalid = 1'b0;
    #1;
    chk("t4_iack_c8", inst_ack, 0);
    chk("t4_irdata_keep", inst_rdata, 32'h27BD_FFE8);
    chk("t4_rready_c8", rready, 0);
    chk("t4_stall_c8", stall, 1);
    step;
    chk("t4_arvalid_c9", arvalid, 1);
    chk("t4_araddr_c9", araddr, 32'hBFC0_0008);
    step;
    chk("t4_rready_c10", rready, 1);
    rvalid = 1'b1;
    rdata = 32'h8FA4_0000;
    step;
    rvalid = 1'b0;
    chk("t4_iack_c11", inst_ack, 1);
    chk("t4_irdata_new", inst_rdata, 32'h8FA4_0000);
    inst_req = 1'b0;
    arready = 1'b0;
    step;

    // reset in the middle of a write
    data_req = 1'b1;
    data_we = 1'b1;
    data_addr = 32'h8000_2000;
    data_wdata = 32'hCAFE_F00D;
    data_sel = 4'hF;
    step;
    chk("t5_awvalid_c1", awvalid, 1);
    rst = 1'b0;
    #1;
    chk("t5_awvalid_rst", awvalid, 0);
    chk("t5_wvalid_rst", wvalid, 0);
    chk("t5_dack_rst", data_ack, 0);
    chk("t5_awaddr_rst", awaddr, 0);
    chk("t5_wstrb_rst", wstrb, 0);
    step;
    chk("t5_awvalid_hold", awvalid, 0);
    chk("t5_dack_hold", data_ack, 0);
    rst = 1'b1;
    awready = 1'b1;
    wready = 1'b1;
    step;
    chk("t5_awvalid_re", awvalid, 1);
    chk("t5_wvalid_re", wvalid, 1);
    chk("t5_awaddr_re", awaddr, 32'h8000_2000);
    chk("t5_wstrb_re", wstrb, 4'hF);
    step;
    awready = 1'b0;
    wready = 1'b0;
    chk("t5_bready", bready, 1);
    chk("t5_awvalid_off", awvalid, 0);
    chk("t5_wvalid_off", wvalid, 0);
    bvalid = 1'b1;
    step;
    bvalid = 1'b0;
    chk("t5_dack", data_ack, 1);
    chk("t5_drdata", data_rdata, 0);
    data_req = 1'b0;
    data_we = 1'b0;
    step;
    chk("t5_dack_end", data_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
